// File: rtl/midi_ctrl.sv
// midi_ctrl: MIDI byte-stream parser.
// Decodes note-on/off, polyphonic key pressure and channel pressure from a
// stream of received bytes, honouring running status, realtime transparency
// and the system reset (0xFF) and read-back (0xF4) commands.
// Handshake: valid_byte is a one-cycle strobe with no back-pressure; data is
// sampled only in a cycle where valid_byte=1. Every event output is a
// registered pulse that appears the cycle after the byte completing it.
module midi_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_byte,
  input  logic [7:0] data,
  output logic       note_presse,
  output logic       note_release,
  output logic       note_keypress,
  output logic       note_channelpress,
  output logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       rst_cmd,
  output logic       read
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;   // running status, 0 when none
  logic [6:0] d1_q, d1_d;           // first data byte of a two-byte message
  logic [3:0] channel_q, channel_d;
  logic [6:0] note_q, note_d;
  logic [6:0] velocity_q, velocity_d;
  logic       presse_q, presse_d;
  logic       release_q, release_d;
  logic       keypress_q, keypress_d;
  logic       chanpress_q, chanpress_d;
  logic       rst_cmd_q, rst_cmd_d;
  logic       read_q, read_d;

  // Message completion helpers.
  logic       done;
  logic [6:0] m_d1;
  logic [6:0] m_d2;
  logic       two_byte;

  // Parser next-state, latched fields and event pulses.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    d1_d        = d1_q;
    channel_d   = channel_q;
    note_d      = note_q;
    velocity_d  = velocity_q;
    presse_d    = 1'b0;
    release_d   = 1'b0;
    keypress_d  = 1'b0;
    chanpress_d = 1'b0;
    rst_cmd_d   = 1'b0;
    read_d      = 1'b0;
    done        = 1'b0;
    m_d1        = d1_q;
    m_d2        = data[6:0];
    // Program change (0xC) and channel pressure (0xD) carry one data byte.
    two_byte    = (status_q[7:4] != 4'hC) && (status_q[7:4] != 4'hD);

    if (valid_byte) begin
      if (data[7]) begin
        if (data[7:4] != 4'hF) begin
          // Channel status: start a fresh message, dropping any partial one.
          status_d = data;
          state_d  = WAIT_D1;
        end else begin
          case (data[3:0])
            4'hF: begin
              rst_cmd_d = 1'b1;
              state_d   = IDLE;
              status_d  = 8'h00;
            end
            4'h4: read_d = 1'b1;
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: ;  // realtime: transparent
            default: begin
              state_d  = IDLE;
              status_d = 8'h00;
            end
          endcase
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            if (two_byte) begin
              d1_d    = data[6:0];
              state_d = WAIT_D2;
            end else begin
              done = 1'b1;
              m_d1 = data[6:0];
            end
          end
          WAIT_D2: begin
            done    = 1'b1;
            state_d = WAIT_D1;
          end
          default: ;  // data without running status is dropped
        endcase
      end
    end

    if (done) begin
      case (status_q[7:4])
        4'h8: begin
          channel_d  = status_q[3:0];
          note_d     = m_d1;
          velocity_d = m_d2;
          release_d  = 1'b1;
        end
        4'h9: begin
          channel_d  = status_q[3:0];
          note_d     = m_d1;
          velocity_d = m_d2;
          presse_d   = (m_d2 != 7'd0);
          release_d  = (m_d2 == 7'd0);
        end
        4'hA: begin
          channel_d  = status_q[3:0];
          note_d     = m_d1;
          velocity_d = m_d2;
          keypress_d = 1'b1;
        end
        4'hD: begin
          channel_d   = status_q[3:0];
          velocity_d  = m_d1;
          chanpress_d = 1'b1;
        end
        default: ;  // 0xB, 0xC, 0xE are consumed silently
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      status_q    <= 8'h00;
      d1_q        <= 7'd0;
      channel_q   <= 4'd0;
      note_q      <= 7'd0;
      velocity_q  <= 7'd0;
      presse_q    <= 1'b0;
      release_q   <= 1'b0;
      keypress_q  <= 1'b0;
      chanpress_q <= 1'b0;
      rst_cmd_q   <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      d1_q        <= d1_d;
      channel_q   <= channel_d;
      note_q      <= note_d;
      velocity_q  <= velocity_d;
      presse_q    <= presse_d;
      release_q   <= release_d;
      keypress_q  <= keypress_d;
      chanpress_q <= chanpress_d;
      rst_cmd_q   <= rst_cmd_d;
      read_q      <= read_d;
    end
  end

  assign note_presse       = presse_q;
  assign note_release      = release_q;
  assign note_keypress     = keypress_q;
  assign note_channelpress = chanpress_q;
  assign channel           = channel_q;
  assign note              = note_q;
  assign velocity          = velocity_q;
  assign rst_cmd           = rst_cmd_q;
  assign read              = read_q;

endmodule

// File: tb/tb_midi_ctrl.sv
// tb_midi_ctrl: randomized and directed bench for midi_ctrl against a
// message-level reference model (running status + pending data list).
module tb_midi_ctrl;

  logic       clk;
  logic       rst;
  logic       valid_byte;
  logic [7:0] data;
  logic       note_presse, note_release, note_keypress, note_channelpress;
  logic [3:0] channel;
  logic [6:0] note, velocity;
  logic       rst_cmd, read;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  midi_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .valid_byte        (valid_byte),
    .data              (data),
    .note_presse       (note_presse),
    .note_release      (note_release),
    .note_keypress     (note_keypress),
    .note_channelpress (note_channelpress),
    .channel           (channel),
    .note              (note),
    .velocity          (velocity),
    .rst_cmd           (rst_cmd),
    .read              (read)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Expected registered outputs after each rising edge.
  logic       e_pres, e_rel, e_kp, e_cp, e_rc, e_rd;
  logic [3:0] e_ch;
  logic [6:0] e_note, e_vel;
  logic [7:0] rs;           // running status byte
  bit         rs_ok;        // a channel status is in force
  logic [6:0] pend[$];      // data bytes collected for the current message

  initial begin
    {e_pres, e_rel, e_kp, e_cp, e_rc, e_rd} = '0;
    e_ch = 0; e_note = 0; e_vel = 0; rs = 0; rs_ok = 0;
  end

  always @(posedge clk) begin
    int need;
    {e_pres, e_rel, e_kp, e_cp, e_rc, e_rd} = '0;
    if (rst) begin
      e_ch = 0; e_note = 0; e_vel = 0; rs_ok = 0; pend.delete();
    end else if (valid_byte) begin
      if (data == 8'hFF) begin
        e_rc = 1; rs_ok = 0; pend.delete();
      end else if (data == 8'hF4) begin
        e_rd = 1;
      end else if (data >= 8'hF8) begin
        // realtime: no effect
      end else if (data >= 8'hF0) begin
        rs_ok = 0; pend.delete();
      end else if (data >= 8'h80) begin
        rs = data; rs_ok = 1; pend.delete();
      end else if (rs_ok) begin
        pend.push_back(data[6:0]);
        need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
        if (pend.size() == need) begin
          case (rs[7:4])
            4'h8: begin e_ch = rs[3:0]; e_note = pend[0]; e_vel = pend[1]; e_rel = 1; end
            4'h9: begin
              e_ch = rs[3:0]; e_note = pend[0]; e_vel = pend[1];
              if (pend[1] != 0) e_pres = 1; else e_rel = 1;
            end
            4'hA: begin e_ch = rs[3:0]; e_note = pend[0]; e_vel = pend[1]; e_kp = 1; end
            4'hD: begin e_ch = rs[3:0]; e_vel = pend[0]; e_cp = 1; end
            default: ;
          endcase
          pend.delete();
        end
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    logic [23:0] got, exp;
    if (cmp_en) begin
      got = {note_presse, note_release, note_keypress, note_channelpress,
             rst_cmd, read, channel, note, velocity};
      exp = {e_pres, e_rel, e_kp, e_cp, e_rc, e_rd, e_ch, e_note, e_vel};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    valid_byte = 1'b1;
    data       = b;
    @(posedge clk);
    #1 valid_byte = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [5:0] pulses();
    return {note_presse, note_release, note_keypress, note_channelpress, rst_cmd, read};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rst = 1'b1; valid_byte = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1;
    @(negedge clk);
    chk("reset_outs", {pulses(), channel, note, velocity}, 32'h0);

    // Note-on with velocity.
    send(8'h93); send(8'h3C); send(8'h64);
    @(negedge clk);
    chk("on_pulse", pulses(), 6'b100000);
    chk("on_fields", {channel, note, velocity}, {4'h3, 7'h3C, 7'h64});
    @(negedge clk);
    chk("on_one_cycle", pulses(), 6'b000000);

    // Running status: on then on-with-zero-velocity.
    send(8'h90); send(8'h40); send(8'h50);
    @(negedge clk);
    chk("rs_on", pulses(), 6'b100000);
    send(8'h40); send(8'h00);
    @(negedge clk);
    chk("rs_off", pulses(), 6'b010000);
    chk("rs_off_fields", {note, velocity}, {7'h40, 7'h00});

    // Note-off then channel pressure keeps note.
    send(8'h85); send(8'h30); send(8'h10);
    @(negedge clk);
    chk("off_pulse", pulses(), 6'b010000);
    chk("off_chan", channel, 4'h5);
    send(8'hD2); send(8'h7F);
    @(negedge clk);
    chk("cp_pulse", pulses(), 6'b000100);
    chk("cp_fields", {channel, note, velocity}, {4'h2, 7'h30, 7'h7F});

    // Realtime byte inside a message, and status interrupting WAIT_D2.
    send(8'h90); send(8'h40); send(8'hF8); send(8'h22);
    @(negedge clk);
    chk("rt_pulse", pulses(), 6'b100000);
    chk("rt_vel", velocity, 7'h22);
    send(8'h90); send(8'h40); send(8'h80); send(8'h41); send(8'h10);
    @(negedge clk);
    chk("interrupt_pulse", pulses(), 6'b010000);
    chk("interrupt_note", note, 7'h41);

    // Polyphonic key pressure.
    send(8'hA7); send(8'h11); send(8'h22);
    @(negedge clk);
    chk("kp_pulse", pulses(), 6'b001000);
    chk("kp_fields", {channel, note, velocity}, {4'h7, 7'h11, 7'h22});

    // System reset command and read request.
    send(8'hFF);
    @(negedge clk);
    chk("rst_cmd_pulse", pulses(), 6'b000010);
    chk("rst_cmd_keeps", {channel, note, velocity}, {4'h7, 7'h11, 7'h22});
    send(8'h40); send(8'h40);
    @(negedge clk);
    chk("after_ff_nopulse", pulses(), 6'b000000);
    send(8'hF4);
    @(negedge clk);
    chk("read_pulse", pulses(), 6'b000001);

    // Reset between status and data.
    send(8'h95);
    pulse_rst();
    @(negedge clk);
    chk("rst_outs_zero", {pulses(), channel, note, velocity}, 32'h0);
    send(8'h40); send(8'h40);
    @(negedge clk);
    chk("rst_no_pulse", {pulses(), channel, note, velocity}, 32'h0);

    // Randomized traffic checked by the every-cycle compare.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        @(posedge clk); #1;
      end else if (r < 10) begin
        pulse_rst();
      end else if (r < 55) begin
        send(8'($urandom_range(0, 127)));
      end else if (r < 85) begin
        send(8'($urandom_range(8'h80, 8'hEF)));
      end else begin
        send(8'($urandom_range(8'hF0, 8'hFF)));
      end
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
